// File: rtl/quickadd_round_ctrl_pkg.sv
// Shared encodings for the quick-add round controller: FSM states,
// round-winner codes and a saturating score increment.
package quickadd_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_WAIT     = 3'd2;
  localparam logic [2:0] ST_ACTIVE   = 3'd3;
  localparam logic [2:0] ST_FLASH    = 3'd4;
  localparam logic [2:0] ST_GAMEOVER = 3'd5;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;

  // Scores stop at the winning score so they can never wrap.
  function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
    return (score >= limit) ? score : score + 4'd1;
  endfunction

endpackage

// File: rtl/quickadd_round_ctrl_if.sv
// Button, datapath and display signals of the round controller.
// The slave side is the controller; the master side drives buttons and match.
interface quickadd_round_ctrl_if;
  logic       go_i;
  logic       press_l_i;
  logic       press_r_i;
  logic       match_i;
  logic       load_o;
  logic       reveal_o;
  logic       flash_o;
  logic [1:0] winner_o;
  logic       correct_o;
  logic [3:0] score_l_o;
  logic [3:0] score_r_o;
  logic [2:0] state_o;

  modport master (
    output go_i, press_l_i, press_r_i, match_i,
    input  load_o, reveal_o, flash_o, winner_o, correct_o,
           score_l_o, score_r_o, state_o
  );

  modport slave (
    input  go_i, press_l_i, press_r_i, match_i,
    output load_o, reveal_o, flash_o, winner_o, correct_o,
           score_l_o, score_r_o, state_o
  );
endinterface

// File: rtl/quickadd_round_ctrl_tick_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module tick_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - WIDTH'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/quickadd_round_ctrl.sv
// Round sequencer for the two-player quick-add game: reveal delay,
// press arbitration, scoring and the result flash window.
module quickadd_round_ctrl
  import quickadd_pkg::*;
#(
  parameter int unsigned WAIT_TICKS  = 200_000_000,
  parameter int unsigned FLASH_TICKS = 400_000_000,
  parameter int unsigned WIN_SCORE   = 9
) (
  input logic                 clkin,
  input logic                 reset,
  quickadd_round_ctrl_if.slave bus
);

  localparam int unsigned MAX_TICKS = (WAIT_TICKS > FLASH_TICKS) ? WAIT_TICKS : FLASH_TICKS;
  localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
  // Timer is loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(WAIT_TICKS - 1);
  localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_TICKS - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  logic [2:0]    state, state_nx;
  logic [1:0]    winner;
  logic          correct;
  logic          tie_right;
  logic [3:0]    score_l, score_r;

  logic          both_press, any_press, dec_left, decided, point_left;
  logic          correct_eff, go_round;
  logic          timer_load, timer_en, timer_done;
  logic [CW-1:0] timer_val;

  tick_timer #(.WIDTH(CW)) u_timer (
    .clk      (clkin),
    .rst      (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (timer_done)
  );

  always_comb begin
    both_press  = bus.press_l_i & bus.press_r_i;
    any_press   = bus.press_l_i | bus.press_r_i;
    dec_left    = both_press ? ~tie_right : bus.press_l_i;
    decided     = any_press && ((state == ST_WAIT) || (state == ST_ACTIVE));
    // A press during WAIT is a false start and always counts as wrong.
    correct_eff = (state == ST_ACTIVE) && bus.match_i;
    point_left  = dec_left ~^ correct_eff;
    go_round    = bus.go_i && ((state == ST_IDLE) || (state == ST_GAMEOVER));
    timer_en    = (state == ST_WAIT) || (state == ST_FLASH);
    timer_load  = 1'b0;
    timer_val   = WAIT_LOAD;
    state_nx    = state;

    case (state)
      ST_IDLE:
        if (bus.go_i) state_nx = ST_LOAD;
      ST_LOAD: begin
        state_nx   = ST_WAIT;
        timer_load = 1'b1;
        timer_val  = WAIT_LOAD;
      end
      ST_WAIT:
        if (any_press) begin
          state_nx   = ST_FLASH;
          timer_load = 1'b1;
          timer_val  = FLASH_LOAD;
        end else if (timer_done) begin
          state_nx = ST_ACTIVE;
        end
      ST_ACTIVE:
        if (any_press) begin
          state_nx   = ST_FLASH;
          timer_load = 1'b1;
          timer_val  = FLASH_LOAD;
        end
      ST_FLASH:
        if (timer_done)
          state_nx = ((score_l == WIN) || (score_r == WIN)) ? ST_GAMEOVER : ST_IDLE;
      ST_GAMEOVER:
        if (bus.go_i) state_nx = ST_LOAD;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= ST_IDLE;
      winner    <= NONE;
      correct   <= 1'b0;
      tie_right <= 1'b0;
      score_l   <= '0;
      score_r   <= '0;
    end else begin
      state <= state_nx;
      if (go_round) begin
        winner  <= NONE;
        correct <= 1'b0;
        if (state == ST_GAMEOVER) begin
          score_l <= '0;
          score_r <= '0;
        end
      end
      if (decided) begin
        winner  <= dec_left ? LEFT : RIGHT;
        correct <= correct_eff;
        if (point_left)
          score_l <= sat_inc(score_l, WIN);
        else
          score_r <= sat_inc(score_r, WIN);
        if (both_press)
          tie_right <= ~tie_right;
      end
    end
  end

  assign bus.load_o    = (state == ST_LOAD);
  assign bus.reveal_o  = (state == ST_ACTIVE);
  assign bus.flash_o   = (state == ST_FLASH);
  assign bus.winner_o  = winner;
  assign bus.correct_o = correct;
  assign bus.score_l_o = score_l;
  assign bus.score_r_o = score_r;
  assign bus.state_o   = state;

endmodule
